// File: rtl/free_list.sv
// Circular FIFO of free physical register tags feeding the rename map table.
// Build option FREE_LIST_BYPASS_EN forwards this cycle's freed tags straight onto the read lanes.
module free_list #(
    parameter int N            = 3,
    parameter int NUM_ARCH     = 31,
    parameter int NUM_PHYS     = 64,
    parameter int DEPTH        = NUM_PHYS - NUM_ARCH - 1,
    parameter int PTR_W        = $clog2(DEPTH) + 1,
    parameter int PHYS_REG_IDX = $clog2(NUM_PHYS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(N+1)-1:0]      rd_num,
    output logic [N*PHYS_REG_IDX-1:0]   free_reg,
    output logic [N-1:0]                free_valid,
    output logic [$clog2(DEPTH+1)-1:0]  num_avail,
    input  logic [N*PHYS_REG_IDX-1:0]   wr_reg,
    input  logic [N-1:0]                wr_valid,
    output logic [PTR_W-1:0]            out_head,
    input  logic                        restore_en,
    input  logic [PTR_W-1:0]            restore_head
);
    localparam int IDX_W = PTR_W - 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = PHYS_REG_IDX;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [W-1:0]     entries_reg [DEPTH];
    logic [W-1:0]     wr_comp [N];
    logic [IDX_W-1:0] wr_idx [N];
    int unsigned      count, avail, wr_cnt, deq, deq_stored, byp_used;

    // Pointer index wraps modulo DEPTH; the MSB toggles on every wrap.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned amt);
        int unsigned idx;
        logic        wrap;
        idx  = 32'(p[IDX_W-1:0]) + amt;
        wrap = p[PTR_W-1];
        if (idx >= DEPTH) begin
            idx  = idx - DEPTH;
            wrap = ~wrap;
        end
        return {wrap, idx[IDX_W-1:0]};
    endfunction

    function automatic logic [IDX_W-1:0] idx_add(input logic [PTR_W-1:0] p, input int unsigned amt);
        logic [PTR_W-1:0] q;
        q = ptr_add(p, amt);
        return q[IDX_W-1:0];
    endfunction

    function automatic int unsigned ptr_diff(input logic [PTR_W-1:0] t, input logic [PTR_W-1:0] h);
        if (t[PTR_W-1] == h[PTR_W-1])
            return 32'(t[IDX_W-1:0]) - 32'(h[IDX_W-1:0]);
        else
            return DEPTH + 32'(t[IDX_W-1:0]) - 32'(h[IDX_W-1:0]);
    endfunction

    // Compact valid, nonzero retire lanes into lane order.
    always_comb begin
        wr_cnt = 0;
        for (int k = 0; k < N; k++) wr_comp[k] = '0;
        for (int k = 0; k < N; k++) begin
            if (wr_valid[k] && (wr_reg[k*W +: W] != '0)) begin
                wr_comp[wr_cnt] = wr_reg[k*W +: W];
                wr_cnt          = wr_cnt + 1;
            end
        end
    end

    always_comb begin
        count = ptr_diff(tail_reg, head_reg);
        avail = count;
`ifdef FREE_LIST_BYPASS_EN
        if (!restore_en) avail = count + wr_cnt;
`endif
        deq = 0;
        if (!restore_en) deq = (32'(rd_num) < avail) ? 32'(rd_num) : avail;
        deq_stored = (deq < count) ? deq : count;
        // Bypassed tags handed out this cycle never touch the array.
        byp_used   = deq - deq_stored;
        head_next  = restore_en ? restore_head : ptr_add(head_reg, deq_stored);
        tail_next  = ptr_add(tail_reg, wr_cnt - byp_used);
        for (int k = 0; k < N; k++) begin
            wr_idx[k] = '0;
            if (k >= byp_used) wr_idx[k] = idx_add(tail_reg, k - byp_used);
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [W-1:0]     tag;
        logic [IDX_W-1:0] rd_idx;
        assign rd_idx = idx_add(head_reg, gi);
        always_comb begin
            tag = '0;
            if (gi < avail) begin
                if (gi < count) tag = entries_reg[rd_idx];
`ifdef FREE_LIST_BYPASS_EN
                else            tag = wr_comp[gi - count];
`endif
            end
        end
        assign free_reg[gi*W +: W] = tag;
        assign free_valid[gi]      = (gi < avail);
    end

    assign num_avail = CNT_W'(count);
    assign out_head  = head_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= {1'b1, {IDX_W{1'b0}}};
            for (int e = 0; e < DEPTH; e++) entries_reg[e] <= W'(NUM_ARCH + 1 + e);
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            for (int k = 0; k < N; k++) begin
                if ((k >= byp_used) && (k < wr_cnt)) entries_reg[wr_idx[k]] <= wr_comp[k];
            end
            assert (ptr_diff(tail_reg, head_next) + wr_cnt - byp_used <= DEPTH);
        end
    end
endmodule
